// File: rtl/rgb_matrix_pkg.sv
// Shared types and default sizing for the RGB matrix scan driver.
// Imported by the frame buffer and the driver top.
package rgb_matrix_pkg;

    localparam int DEF_COLS    = 8;
    localparam int DEF_ROWS    = 8;
    localparam int DEF_BPC     = 1;
    localparam int DEF_CLK_DIV = 128;
    localparam int DEF_DWELL   = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        LATCH,
        DISPLAY,
        BLANK
    } state_t;

endpackage

// File: rtl/rgb_frame_buffer.sv
// Two-bank row memory; one bank is shown while the other is written.
// Read returns a single bit plane of one row as an {R,G,B} message.
module rgb_frame_buffer
    import rgb_matrix_pkg::*;
#(
    parameter int  COLS = DEF_COLS,
    parameter int  ROWS = DEF_ROWS,
    parameter int  BPC  = DEF_BPC,
    localparam int DW   = 3 * COLS * BPC,
    localparam int RW   = $clog2(ROWS),
    localparam int PW   = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [RW-1:0]     wr_row,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_bank,
    input  logic [RW-1:0]     rd_row,
    input  logic [PW-1:0]     rd_plane,
    output logic [3*COLS-1:0] rd_msg
);

    logic [DW-1:0] mem [2][ROWS];
    logic [DW-1:0] row_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (wr_en && (int'(wr_row) < ROWS)) begin
            mem[wr_bank][wr_row] <= wr_data;
        end
    end

    // Forward a same-cycle write so a capture never sees stale data.
    always_comb begin
        row_word = mem[rd_bank][rd_row];
        if (wr_en && (wr_bank == rd_bank) && (wr_row == rd_row)) begin
            row_word = wr_data;
        end
        rd_msg = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int c = 0; c < COLS; c++) begin
                rd_msg[ch*COLS + c] =
                    row_word[ch*COLS*BPC + c*BPC + int'(rd_plane)];
            end
        end
    end

endmodule

// File: rtl/rgb_matrix_driver.sv
// Row-multiplexed RGB matrix driver with binary-coded modulation
// and double-buffered frame memory.
module rgb_matrix_driver
    import rgb_matrix_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int BPC     = DEF_BPC,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DWELL   = DEF_DWELL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [3*COLS*BPC-1:0]     wr_data,
    input  logic                      swap,
    output logic                      SH_CP,
    output logic                      ST_CP,
    output logic                      DS,
    output logic                      OE,
    output logic                      SR_CLR,
    output logic [ROWS-1:0]           KATOT,
    output logic                      frame_done,
    output logic                      swap_pending
);

    localparam int RW  = $clog2(ROWS);
    localparam int PW  = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int CW  = $clog2(CLK_DIV);
    localparam int MW  = 3 * COLS;
    localparam int BW  = $clog2(MW);
    localparam int DCW = $clog2((DWELL << (BPC - 1)) + 1);
    localparam logic [ROWS-1:0] ROW0 = ROWS'(1) << (ROWS - 1);

    state_t         state;
    logic [CW-1:0]  div_cnt;
    logic           tick;
    logic [RW-1:0]  row;
    logic [PW-1:0]  plane;
    logic [MW-1:0]  msg;
    logic [BW-1:0]  bit_cnt;
    logic           phase;
    logic           sub;
    logic [DCW-1:0] dcnt;
    logic           front_sel;

    logic           pl_last;
    logic           row_last;
    logic [PW-1:0]  nxt_plane;
    logic [RW-1:0]  nxt_row;
    logic           frame_end;
    logic           apply;
    logic           load;
    logic           dwell_last;
    logic [RW-1:0]  rd_row;
    logic [PW-1:0]  rd_plane;
    logic [MW-1:0]  rd_msg;

    assign tick = (div_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_comb begin
        pl_last    = (plane == PW'(BPC - 1));
        row_last   = (row == RW'(ROWS - 1));
        nxt_plane  = pl_last ? '0 : plane + 1'b1;
        nxt_row    = row;
        if (pl_last) begin
            nxt_row = row_last ? '0 : row + 1'b1;
        end
        frame_end  = (state == BLANK) && pl_last && row_last;
        apply      = frame_end && tick && swap_pending;
        load       = tick && (((state == CLEAR) && sub) ||
                     ((state == BLANK) && (!frame_end || enable)));
        dwell_last = (dcnt == DCW'((DWELL << plane) - 1));
        rd_row     = (state == BLANK) ? nxt_row : '0;
        rd_plane   = (state == BLANK) ? nxt_plane : '0;
    end

    // Reads go to the bank that will be front after any pending swap.
    rgb_frame_buffer #(
        .COLS (COLS),
        .ROWS (ROWS),
        .BPC  (BPC)
    ) u_fb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_bank  (~front_sel),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .rd_bank  (front_sel ^ apply),
        .rd_row   (rd_row),
        .rd_plane (rd_plane),
        .rd_msg   (rd_msg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            SH_CP        <= 1'b0;
            ST_CP        <= 1'b0;
            DS           <= 1'b0;
            OE           <= 1'b1;
            SR_CLR       <= 1'b1;
            KATOT        <= '0;
            frame_done   <= 1'b0;
            swap_pending <= 1'b0;
            front_sel    <= 1'b0;
            row          <= '0;
            plane        <= '0;
            msg          <= '0;
            bit_cnt      <= '0;
            phase        <= 1'b0;
            sub          <= 1'b0;
            dcnt         <= '0;
        end else begin
            frame_done <= 1'b0;
            if (apply) begin
                swap_pending <= 1'b0;
                front_sel    <= ~front_sel;
            end else if (swap) begin
                swap_pending <= 1'b1;
            end
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (enable) begin
                            state  <= CLEAR;
                            SR_CLR <= 1'b0;
                            sub    <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        if (!sub) begin
                            sub <= 1'b1;
                        end else begin
                            SR_CLR <= 1'b1;
                            row    <= '0;
                            plane  <= '0;
                        end
                    end
                    SHIFT: begin
                        if (!phase) begin
                            SH_CP <= 1'b1;
                            phase <= 1'b1;
                        end else if (bit_cnt == BW'(MW - 1)) begin
                            SH_CP <= 1'b0;
                            ST_CP <= 1'b1;
                            DS    <= 1'b0;
                            sub   <= 1'b0;
                            state <= LATCH;
                        end else begin
                            SH_CP   <= 1'b0;
                            DS      <= msg[1];
                            msg     <= msg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            phase   <= 1'b0;
                        end
                    end
                    LATCH: begin
                        if (!sub) begin
                            ST_CP <= 1'b0;
                            sub   <= 1'b1;
                        end else begin
                            state <= DISPLAY;
                            OE    <= 1'b0;
                            KATOT <= ROW0 >> row;
                            dcnt  <= '0;
                        end
                    end
                    DISPLAY: begin
                        if (dwell_last) begin
                            state <= BLANK;
                            OE    <= 1'b1;
                            KATOT <= '0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    BLANK: begin
                        plane <= nxt_plane;
                        row   <= nxt_row;
                        if (frame_end) begin
                            frame_done <= 1'b1;
                            if (!enable) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (load) begin
                    state   <= SHIFT;
                    msg     <= rd_msg;
                    DS      <= rd_msg[0];
                    SH_CP   <= 1'b0;
                    bit_cnt <= '0;
                    phase   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_matrix_driver.sv
// Scoreboard bench: expected row records are queued by the stimulus
// and popped by a monitor that rebuilds each shifted/displayed row.
module tb_rgb_matrix_driver;

    localparam int COLS    = 8;
    localparam int ROWS    = 8;
    localparam int BPC     = 2;
    localparam int CLK_DIV = 4;
    localparam int DWELL   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_row = '0;
    logic [47:0] wr_data = '0;
    logic        swap = 1'b0;
    logic        SH_CP, ST_CP, DS, OE, SR_CLR;
    logic [7:0]  KATOT;
    logic        frame_done, swap_pending;

    always #5 clk = ~clk;

    rgb_matrix_driver #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .BPC     (BPC),
        .CLK_DIV (CLK_DIV),
        .DWELL   (DWELL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .swap         (swap),
        .SH_CP        (SH_CP),
        .ST_CP        (ST_CP),
        .DS           (DS),
        .OE           (OE),
        .SR_CLR       (SR_CLR),
        .KATOT        (KATOT),
        .frame_done   (frame_done),
        .swap_pending (swap_pending)
    );

    typedef struct {
        logic [23:0] data;
        logic [7:0]  katot;
        int          len;
        int          nbits;
    } rec_t;

    rec_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          viol = 0;
    logic [23:0] img [2][8][2];
    int          front = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // {R,G,B} plane messages -> wr_data layout (channel, column, plane).
    function automatic logic [47:0] pack(input logic [23:0] m0,
                                         input logic [23:0] m1);
        logic [47:0] d;
        d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int c = 0; c < 8; c++) begin
                d[ch*16 + c*2]     = m0[ch*8 + c];
                d[ch*16 + c*2 + 1] = m1[ch*8 + c];
            end
        end
        return d;
    endfunction

    task automatic write_row(input int r, input logic [23:0] m0,
                             input logic [23:0] m1);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_row  = 3'(r);
        wr_data = pack(m0, m1);
        img[1-front][r][0] = m0;
        img[1-front][r][1] = m1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_swap();
        @(negedge clk);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
    endtask

    task automatic push_frame(input int b);
        rec_t e;
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < 2; p++) begin
                e.data  = img[b][r][p];
                e.katot = 8'h80 >> r;
                e.len   = (p == 0) ? 12 : 24;
                e.nbits = 24;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            compared++;
            mismatched++;
            $display("FAIL %s: frame_done timeout", name);
        end
    endtask

    initial begin : monitor
        logic        prev_sh, prev_st, prev_oe;
        logic [23:0] acc;
        int          nb, oe_len, rec_cnt;
        rec_t        cur, e;
        prev_sh = 1'b0; prev_st = 1'b0; prev_oe = 1'b1;
        acc = '0; nb = 0; oe_len = 0; rec_cnt = 0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_sh = 1'b0; prev_st = 1'b0; prev_oe = 1'b1;
                acc = '0; nb = 0; oe_len = 0; rec_cnt = 0;
            end else begin
                if (SH_CP && !prev_sh) begin
                    if (nb < 24) acc[nb] = DS;
                    nb++;
                end
                if (ST_CP && !prev_st) begin
                    cur.data  = acc;
                    cur.nbits = nb;
                    acc = '0;
                    nb  = 0;
                end
                if (!OE) begin
                    if (prev_oe) cur.katot = KATOT;
                    else if (KATOT !== cur.katot) viol++;
                    oe_len++;
                end
                if (OE && KATOT !== 8'h00) viol++;
                if (OE && !prev_oe) begin
                    cur.len = oe_len;
                    oe_len  = 0;
                    rec_cnt++;
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL row_rec: unexpected row %h", cur.data);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur.data !== e.data || cur.katot !== e.katot ||
                            cur.len != e.len || cur.nbits != e.nbits) begin
                            mismatched++;
                            $display("FAIL row_rec: got d=%h k=%h len=%0d n=%0d, want d=%h k=%h len=%0d n=%0d",
                                     cur.data, cur.katot, cur.len, cur.nbits,
                                     e.data, e.katot, e.len, e.nbits);
                        end
                    end
                end
                if (frame_done) begin
                    check("frame_rows", 64'(rec_cnt), 64'd16);
                    rec_cnt = 0;
                end
                prev_sh = SH_CP;
                prev_st = ST_CP;
                prev_oe = OE;
            end
        end
    end

    initial begin : stim
        int n, sh_edges, oe_low;
        logic prev;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                for (int p = 0; p < 2; p++)
                    img[b][r][p] = '0;

        repeat (3) @(negedge clk);
        check("rst_sh_cp", 64'(SH_CP), 64'd0);
        check("rst_st_cp", 64'(ST_CP), 64'd0);
        check("rst_ds", 64'(DS), 64'd0);
        check("rst_oe", 64'(OE), 64'd1);
        check("rst_sr_clr", 64'(SR_CLR), 64'd1);
        check("rst_katot", 64'(KATOT), 64'd0);
        check("rst_fd", 64'(frame_done), 64'd0);
        check("rst_pending", 64'(swap_pending), 64'd0);
        rst_n = 1'b1;

        write_row(3, 24'h0000A5, 24'h3C0000);
        write_row(5, 24'h00FF00, 24'h000000);
        do_swap();
        check("pending_set", 64'(swap_pending), 64'd1);
        do_swap();
        check("pending_hold", 64'(swap_pending), 64'd1);
        push_frame(0);
        push_frame(1);
        enable = 1'b1;

        wait_fd("frame1");
        check("pending_clr1", 64'(swap_pending), 64'd0);
        front = 1;

        repeat (100) @(negedge clk);
        write_row(0, 24'h123456, 24'hABCDEF);
        do_swap();
        check("pending_mid", 64'(swap_pending), 64'd1);
        push_frame(0);
        wait_fd("frame2");
        check("pending_clr2", 64'(swap_pending), 64'd0);
        front = 0;

        repeat (100) @(negedge clk);
        enable = 1'b0;
        wait_fd("frame3");
        sh_edges = 0;
        oe_low   = 0;
        prev     = SH_CP;
        repeat (300) begin
            @(negedge clk);
            if (SH_CP && !prev) sh_edges++;
            if (!OE) oe_low++;
            prev = SH_CP;
        end
        check("idle_sh_edges", 64'(sh_edges), 64'd0);
        check("idle_oe_low", 64'(oe_low), 64'd0);
        check("q_empty3", 64'(exp_q.size()), 64'd0);

        push_frame(0);
        enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!SH_CP && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("shift_seen", 64'(SH_CP), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_oe", 64'(OE), 64'd1);
        check("async_katot", 64'(KATOT), 64'd0);
        check("async_sr_clr", 64'(SR_CLR), 64'd1);
        check("async_sh_cp", 64'(SH_CP), 64'd0);
        exp_q.delete();
        enable = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                for (int p = 0; p < 2; p++)
                    img[b][r][p] = '0;
        front = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_pending", 64'(swap_pending), 64'd0);
        push_frame(0);
        enable = 1'b1;
        wait_fd("frame_after_rst");
        repeat (2) @(negedge clk);
        check("q_empty_end", 64'(exp_q.size()), 64'd0);
        check("katot_when_oe_off", 64'(viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
